// File: rtl/button_blinker_pkg.sv
// Shared types and helpers for the button/LED blinker.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package button_blinker_pkg;

  // LED mode, also the encoding presented on the MODE output.
  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_SLOW = 2'd1,
    MODE_FAST = 2'd2,
    MODE_ON   = 2'd3
  } mode_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce.sv
// Two-flop synchroniser plus debounce counter for one asynchronous input pin.
// Latency: a level held from edge k is accepted on out at edge k+1+CYCLES.
// Backpressure: none; free-running sampler, out is a level.
module debounce
  import button_blinker_pkg::*;
#(
  parameter int CYCLES = 160000
) (
  input  logic CLK,
  input  logic RST,
  input  logic in,
  output logic out
);

  localparam int             CW       = cnt_width(CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  // Bring the raw pin into the clock domain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= in;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive cycles of disagreement; accept the new level once it has held long enough.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (r_sync2 != r_stable) begin
      if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign out = r_stable;

endmodule

// File: rtl/button_blinker.sv
// Debounced push-button cycling LED mode OFF/SLOW/FAST/ON; long press forces OFF.
// Latency: MODE/PRESS/LONG register one edge after the debounced level changes; LED follows MODE same edge.
// Backpressure: none; PRESS and LONG are single-cycle pulses with no handshake.
module button_blinker
  import button_blinker_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 160000,
  parameter int HOLD_CYCLES     = 16000000,
  parameter int SLOW_HALF       = 8000000,
  parameter int FAST_HALF       = 2000000,
  parameter int NUM_LEDS        = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                BTN,
  output logic [NUM_LEDS-1:0] LED,
  output logic [1:0]          MODE,
  output logic                PRESS,
  output logic                LONG
);

  localparam int            HW        = cnt_width(HOLD_CYCLES);
  localparam int            BW        = cnt_width(SLOW_HALF);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] SLOW_LAST = BW'(SLOW_HALF - 1);
  localparam logic [BW-1:0] FAST_LAST = BW'(FAST_HALF - 1);

  logic          w_stable;
  logic          r_stable_d;
  logic          w_rise;
  logic          w_fall;
  logic [HW-1:0] r_hold_cnt;
  logic          w_long_hit;

  mode_t         r_mode;
  mode_t         w_mode_nxt;
  logic          r_press;
  logic          w_press_nxt;
  logic          r_long;
  logic          w_long_nxt;
  logic          r_fired;
  logic          w_fired_nxt;
  logic          w_mode_chg;

  logic [BW-1:0] r_blink_cnt;
  logic [BW-1:0] w_half_last;
  logic          w_blinking;
  logic          r_phase;
  logic [NUM_LEDS-1:0] w_led;

  debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_db (
    .CLK (CLK),
    .RST (RST),
    .in  (BTN),
    .out (w_stable)
  );

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_stable_d <= 1'b0;
    else     r_stable_d <= w_stable;
  end

  assign w_rise = w_stable & ~r_stable_d;
  assign w_fall = ~w_stable & r_stable_d;

  // Time how long the button has been held; parks at the last count so it cannot wrap.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                        r_hold_cnt <= '0;
    else if (!w_stable)             r_hold_cnt <= '0;
    else if (r_hold_cnt != HOLD_LAST) r_hold_cnt <= r_hold_cnt + 1'b1;
  end

  // The fired flag keeps LONG to a single pulse per press and suppresses the release advance.
  assign w_long_hit = w_stable && (r_hold_cnt == HOLD_LAST) && !r_fired;

  // Mode FSM state and pulse registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mode  <= MODE_OFF;
      r_press <= 1'b0;
      r_long  <= 1'b0;
      r_fired <= 1'b0;
    end else begin
      r_mode  <= w_mode_nxt;
      r_press <= w_press_nxt;
      r_long  <= w_long_nxt;
      r_fired <= w_fired_nxt;
    end
  end

  // Next mode: long press wins and forces OFF; a release advances only if no long press fired.
  always_comb begin
    w_mode_nxt  = r_mode;
    w_press_nxt = 1'b0;
    w_long_nxt  = 1'b0;
    w_fired_nxt = r_fired;
    if (w_long_hit) begin
      w_long_nxt  = 1'b1;
      w_mode_nxt  = MODE_OFF;
      w_fired_nxt = 1'b1;
    end else if (w_fall) begin
      if (!r_fired) begin
        w_press_nxt = 1'b1;
        case (r_mode)
          MODE_OFF:  w_mode_nxt = MODE_SLOW;
          MODE_SLOW: w_mode_nxt = MODE_FAST;
          MODE_FAST: w_mode_nxt = MODE_ON;
          default:   w_mode_nxt = MODE_OFF;
        endcase
      end else begin
        w_fired_nxt = 1'b0;
      end
    end
  end

  assign w_mode_chg  = (w_mode_nxt != r_mode);
  assign w_blinking  = (r_mode == MODE_SLOW) || (r_mode == MODE_FAST);
  assign w_half_last = (r_mode == MODE_SLOW) ? SLOW_LAST : FAST_LAST;

  // Blink timebase: restart with phase high on every mode change so the first half-period is full length.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (w_mode_chg) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (w_blinking) begin
      if (r_blink_cnt == w_half_last) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end else begin
      r_blink_cnt <= '0;
    end
  end

  // LED decode: neighbouring LEDs alternate while blinking.
  always_comb begin
    w_led = '0;
    case (r_mode)
      MODE_ON: w_led = '1;
      MODE_SLOW, MODE_FAST: begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          w_led[i] = i[0] ? ~r_phase : r_phase;
        end
      end
      default: w_led = '0;
    endcase
  end

  assign LED   = w_led;
  assign MODE  = r_mode;
  assign PRESS = r_press;
  assign LONG  = r_long;

endmodule

// File: doc/button_blinker.md
# button_blinker

Parametrised successor to the board-level button/LED blinker. It synchronises and debounces a raw push-button. A short press cycles the LED mode through OFF, SLOW, FAST and ON, and a long press forces OFF. NUM_LEDS outputs are driven, alternating in the blink modes. It sits directly under the TinyFPGA BX top level, between a button pin and the LED pins; USBPU stays in the top level.

## Interface
- DEBOUNCE_CYCLES, default 160000: consecutive stable cycles needed to accept a button level change (10 ms at 16 MHz); must be ≥ 2.
- HOLD_CYCLES, default 16000000: cycles the debounced level must stay high to register a long press; must be ≥ 1.
- SLOW_HALF, default 8000000: half-period of SLOW blink in cycles; must be ≥ FAST_HALF.
- FAST_HALF, default 2000000: half-period of FAST blink in cycles; must be ≥ 1.
- NUM_LEDS, default 1: number of LED outputs; must be ≥ 1.
- CLK  in  1  system clock, 16 MHz on board.
- RST  in  1  reset, asynchronous, active-high.
- BTN  in  1  raw button, active-high, asynchronous to CLK.
- LED  out  NUM_LEDS  LED drive.
- MODE  out  2  current mode: 0 = OFF, 1 = SLOW, 2 = FAST, 3 = ON.
- PRESS  out  1  one-cycle pulse on an accepted short press.
- LONG  out  1  one-cycle pulse when a long press fires.

## Operation
- **Reset:**
  - MODE = OFF, LED = 0, PRESS = 0, LONG = 0.
  - Synchroniser flops = 0, debounced level = 0.
  - All counters = 0, phase = 0, hold-fired flag = 0.
  - Reset asserted mid-blink or mid-press aborts immediately. After release, a still-held button must re-debounce from 0.
- **Synchroniser:** two flops on BTN produce btn_s.
- **Debounce:**
  - While btn_s ≠ stable, db_cnt increments; when btn_s = stable, db_cnt clears.
  - When btn_s ≠ stable and db_cnt = DEBOUNCE_CYCLES−1, stable takes btn_s and db_cnt clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
- **Edge detect:** stable_d is stable delayed one cycle; rise = stable & ~stable_d, fall = ~stable & stable_d.
- **Hold:**
  - hold_cnt increments while stable = 1 and saturates at HOLD_CYCLES−1; it clears while stable = 0.
  - When stable = 1, hold_cnt = HOLD_CYCLES−1 and fired = 0: pulse LONG, set MODE to OFF, set fired. LONG fires exactly once per press.
- **Short press:**
  - On fall with fired = 0: pulse PRESS, MODE advances OFF→SLOW→FAST→ON→OFF, wrapping from 3 to 0.
  - On fall with fired = 1: no advance, no PRESS; fired clears.
- **Blink:**
  - Any MODE change clears blink_cnt and sets phase = 1.
  - In SLOW and FAST, blink_cnt counts 0..HALF−1, with HALF = SLOW_HALF or FAST_HALF. At HALF−1, phase toggles and blink_cnt clears.
  - In OFF and ON, blink_cnt holds at 0.
- **LED decode (combinational from registered MODE and phase):**
  - OFF: all 0.
  - ON: all 1.
  - SLOW/FAST: LED[i] = phase for even i, ~phase for odd i.
- **Widths:** blink_cnt is $clog2(SLOW_HALF) bits, db_cnt is $clog2(DEBOUNCE_CYCLES) bits, hold_cnt is $clog2(HOLD_CYCLES) bits, with a minimum of 1 bit each.

## Timing
- If BTN first samples a new level at edge k, stable changes at edge k+1+DEBOUNCE_CYCLES. MODE, PRESS and LONG update at edge k+2+DEBOUNCE_CYCLES or later.
- PRESS and LONG are high for exactly one cycle and never together.
- LED changes on the same edge as MODE. The first blink half-period after entry lasts HALF cycles with phase = 1.
- LONG fires HOLD_CYCLES cycles after stable rises, at edge r+HOLD_CYCLES where r is the rising edge of stable.
- Releasing the button at or before hold_cnt reaches HOLD_CYCLES−1 is a short press.

## Structure
- Package button_blinker_pkg holds the mode constants MODE_OFF, MODE_SLOW, MODE_FAST and MODE_ON (2-bit).
- Sub-module debounce holds the synchroniser and the debounce counter. It has parameter CYCLES, ports CLK, RST, in, out (stable), and is reusable for other pins.
- The top of the block contains edge detect, hold logic, the mode FSM, the blink counter and the LED decode.

## Test plan
Use DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, SLOW_HALF=8, FAST_HALF=3, NUM_LEDS=2.
- Reset, then hold BTN=0 for 50 cycles → MODE=0, LED=2'b00, PRESS and LONG never high.
- BTN high for 10 cycles, then low → PRESS pulse at fall+6 cycles (2 sync + 4 debounce). MODE=1 and LED=2'b01 on that edge; LED toggles every 8 cycles (2'b10, 2'b01, …).
- Three more short presses → MODE 2 (LED toggles every 3 cycles), then 3 (LED=2'b11), then wraps to 0 (LED=2'b00).
- BTN pulses of 1–3 cycles separated by ≥ 5 low cycles → stable never changes, no PRESS, MODE unchanged.
- From MODE=2, hold BTN high for 40 cycles, then release → LONG once at 20 cycles after stable rises, MODE=0. No PRESS and no advance on release.
- Assert RST mid-SLOW with BTN held high → MODE, LED, PRESS and LONG = 0 immediately. After release, stable returns to 1 only after 2+4 cycles.
